uart_tx_cfg: RTL

Runtime-configurable UART transmitter with an internal baud divider and a one-entry holding buffer. Data length, parity enable and type, stop-bit count and bit period are selectable at run time. A valid/ready handshake lets the next word be accepted while the current frame is still on the line, so frames go out back-to-back with no idle gap. It replaces the fixed 8-bit, one-clock-per-bit transmitter at the UART system's TX boundary.

---
 rtl/uart_tx_cfg.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: baud divider, one-entry holding buffer,
// per-frame shadowed config (length, parity, stop bits, bit period).
module uart_tx_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16,
  localparam int LEN_W     = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  output logic                  Data_Ready,
  input  logic [LEN_W-1:0]      data_len,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  input  logic                  two_stop,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  frame_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_t;

  state_t                r_state;
  state_t                w_stateNext;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_holdFull;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shiftNext;
  logic [DIV_WIDTH-1:0]  r_timer;
  logic [DIV_WIDTH-1:0]  w_timerNext;
  logic [LEN_W-1:0]      r_bitCnt;
  logic [LEN_W-1:0]      w_bitCntNext;
  logic [LEN_W-1:0]      r_len;
  logic                  r_parEn;
  logic                  r_twoStop;
  logic [DIV_WIDTH-1:0]  r_div;
  logic                  r_parBit;
  logic                  r_txOut;
  logic                  w_txNext;
  logic                  w_accept;
  logic                  w_load;
  logic                  w_frameEnd;
  logic                  w_bitEnd;
  logic [LEN_W-1:0]      w_effLen;
  logic                  w_calcParity;

  assign w_accept   = Data_Valid && !r_holdFull;
  assign w_bitEnd   = (r_timer == '0);
  assign Data_Ready = !r_holdFull;
  assign TX_OUT     = r_txOut;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = w_frameEnd;

  // Out-of-range lengths fall back to the full word width.
  always_comb begin
    w_effLen = data_len;
    if (data_len < LEN_W'(5) || data_len > LEN_W'(DATA_WIDTH)) begin
      w_effLen = LEN_W'(DATA_WIDTH);
    end
  end

  always_comb begin
    w_calcParity = parity_type;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (LEN_W'(i) < w_effLen) begin
        w_calcParity = w_calcParity ^ r_hold[i];
      end
    end
  end

  always_comb begin
    w_stateNext  = r_state;
    w_shiftNext  = r_shift;
    w_timerNext  = r_timer;
    w_bitCntNext = r_bitCnt;
    w_load       = 1'b0;
    w_frameEnd   = 1'b0;

    if (r_state != S_IDLE && !w_bitEnd) begin
      w_timerNext = r_timer - DIV_WIDTH'(1);
    end

    case (r_state)
      S_IDLE: begin
        w_load = r_holdFull;
      end
      S_START: begin
        if (w_bitEnd) begin
          w_stateNext  = S_DATA;
          w_timerNext  = r_div;
          w_bitCntNext = '0;
        end
      end
      S_DATA: begin
        if (w_bitEnd) begin
          w_timerNext = r_div;
          w_shiftNext = r_shift >> 1;
          if (r_bitCnt == r_len - LEN_W'(1)) begin
            w_stateNext  = r_parEn ? S_PARITY : S_STOP1;
            w_bitCntNext = '0;
          end else begin
            w_bitCntNext = r_bitCnt + LEN_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (w_bitEnd) begin
          w_stateNext = S_STOP1;
          w_timerNext = r_div;
        end
      end
      S_STOP1: begin
        if (w_bitEnd) begin
          if (r_twoStop) begin
            w_stateNext = S_STOP2;
            w_timerNext = r_div;
          end else begin
            w_frameEnd = 1'b1;
          end
        end
      end
      S_STOP2: begin
        w_frameEnd = w_bitEnd;
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase

    if (w_frameEnd) begin
      w_load      = r_holdFull;
      w_stateNext = S_IDLE;
    end

    // A pending word starts its frame on the very next edge, so no idle gap.
    if (w_load) begin
      w_stateNext  = S_START;
      w_shiftNext  = r_hold;
      w_timerNext  = baud_div;
      w_bitCntNext = '0;
    end
  end

  always_comb begin
    w_txNext = 1'b1;
    case (w_stateNext)
      S_START:  w_txNext = 1'b0;
      S_DATA:   w_txNext = w_shiftNext[0];
      S_PARITY: w_txNext = r_parBit;
      default:  w_txNext = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_timer    <= '0;
      r_bitCnt   <= '0;
      r_txOut    <= 1'b1;
      r_hold     <= '0;
      r_holdFull <= 1'b0;
      r_len      <= LEN_W'(DATA_WIDTH);
      r_parEn    <= 1'b0;
      r_twoStop  <= 1'b0;
      r_div      <= '0;
      r_parBit   <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_shift  <= w_shiftNext;
      r_timer  <= w_timerNext;
      r_bitCnt <= w_bitCntNext;
      r_txOut  <= w_txNext;
      if (w_accept) begin
        r_hold <= P_DATA;
      end
      if (w_accept) begin
        r_holdFull <= 1'b1;
      end else if (w_load) begin
        r_holdFull <= 1'b0;
      end
      if (w_load) begin
        r_len     <= w_effLen;
        r_parEn   <= parity_enable;
        r_twoStop <= two_stop;
        r_div     <= baud_div;
        r_parBit  <= w_calcParity;
      end
    end
  end

endmodule
